// File: rtl/mult_result_bcd.sv
// mult_result_bcd
//   Takes the 8-bit product of the 4x4 shift-add multiplier, turns it into
//   three BCD digits with a one-bit-per-clock double-dabble engine, holds the
//   last completed result and scans it onto a multiplexed 7-segment display.
//
// Ports
//   clk         in   1   system clock, all state on rising edge
//   rst_n       in   1   asynchronous active-low reset
//   prod        in   8   unsigned product 0..255
//   prod_valid  in   1   product valid, sampled only while in_ready=1
//   in_ready    out  1   converter idle, next valid product is accepted
//   busy        out  1   conversion in progress (inverse of in_ready)
//   done        out  1   one-cycle pulse, bcd_out has just been updated
//   bcd_out     out  12  {hundreds, tens, ones}, held until the next done
//   seg         out  7   {g,f,e,d,c,b,a} active-high segments of current digit
//   digit_en    out  3   one-hot digit select: [0]=ones [1]=tens [2]=hundreds
//
// Parameters
//   SCAN_DIV    clocks each digit is shown before the scan advances (>=2)
//   BLANK_LZ    1 = blank leading-zero hundreds/tens digits

module mult_result_bcd #(
    parameter int SCAN_DIV = 1024,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  prod,
    input  logic        prod_valid,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd_out,
    output logic [6:0]  seg,
    output logic [2:0]  digit_en
);

    localparam int                SCAN_W    = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    // {hundreds, tens, ones, binary}; the binary byte drains into the BCD
    // nibbles one bit per shift.
    logic [19:0]       r_shift;
    logic [19:0]       w_shift_nxt;
    logic [19:0]       w_adj;
    logic [19:0]       w_shl;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic [11:0]       r_bcd;
    logic [11:0]       w_bcd_nxt;
    logic              r_done;
    logic              w_done_nxt;

    logic [SCAN_W-1:0] r_scan;
    logic [2:0]        r_digit;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic [6:0]        w_seg_raw;

    // Double-dabble step: any BCD nibble >=5 gets +3 so that the following
    // left shift carries correctly into the next decimal digit.
    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < 3; i++) begin
            if (r_shift[8+4*i +: 4] >= 4'd5) begin
                w_adj[8+4*i +: 4] = r_shift[8+4*i +: 4] + 4'd3;
            end
        end
        w_shl = w_adj << 1;
    end

    // NOTE: every signal gets its default before the case statement, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_bcd_nxt   = r_bcd;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (prod_valid) begin
                    w_shift_nxt = {12'h000, prod};
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_shift_nxt = w_shl;
                w_cnt_nxt   = r_cnt + 3'd1;
                // Eighth shift: the BCD digits are complete in the upper bits.
                if (r_cnt == 3'd7) begin
                    w_bcd_nxt   = w_shl[19:8];
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bcd   <= w_bcd_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state == SHIFT);
    assign done     = r_done;
    assign bcd_out  = r_bcd;

    // Display scan runs freely, regardless of conversion activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan  <= '0;
            r_digit <= 3'b001;
        end else if (r_scan == SCAN_LAST) begin
            r_scan  <= '0;
            r_digit <= {r_digit[1:0], r_digit[2]};
        end else begin
            r_scan  <= r_scan + SCAN_W'(1);
        end
    end

    assign digit_en = r_digit;

    // Select the digit being shown; tens blanks only when hundreds is also 0.
    always_comb begin
        w_nib   = r_bcd[3:0];
        w_blank = 1'b0;
        case (r_digit)
            3'b010: begin
                w_nib   = r_bcd[7:4];
                w_blank = BLANK_LZ && (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
            end
            3'b100: begin
                w_nib   = r_bcd[11:8];
                w_blank = BLANK_LZ && (r_bcd[11:8] == 4'd0);
            end
            default: ;
        endcase
    end

    always_comb begin
        case (w_nib)
            4'd0:    w_seg_raw = 7'h3F;
            4'd1:    w_seg_raw = 7'h06;
            4'd2:    w_seg_raw = 7'h5B;
            4'd3:    w_seg_raw = 7'h4F;
            4'd4:    w_seg_raw = 7'h66;
            4'd5:    w_seg_raw = 7'h6D;
            4'd6:    w_seg_raw = 7'h7D;
            4'd7:    w_seg_raw = 7'h07;
            4'd8:    w_seg_raw = 7'h7F;
            4'd9:    w_seg_raw = 7'h6F;
            default: w_seg_raw = 7'h00;
        endcase
    end

    assign seg = w_blank ? 7'h00 : w_seg_raw;

endmodule

// File: tb/tb_mult_result_bcd.sv
// Testbench for mult_result_bcd: table-driven vectors, hand sequences for the
// latency / overlap / reset corners, an exhaustive sweep and a random phase,
// with a transaction-level model checked on every falling edge.

module tb_mult_result_bcd;

    localparam int SD = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  prod;
    logic        prod_valid;

    logic        in_ready, busy, done;
    logic [11:0] bcd_out;
    logic [6:0]  seg;
    logic [2:0]  digit_en;

    logic        nb_in_ready, nb_busy, nb_done;
    logic [11:0] nb_bcd_out;
    logic [6:0]  nb_seg;
    logic [2:0]  nb_digit_en;

    int n_checks = 0;
    int n_err    = 0;

    mult_result_bcd #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .prod(prod), .prod_valid(prod_valid),
        .in_ready(in_ready), .busy(busy), .done(done), .bcd_out(bcd_out),
        .seg(seg), .digit_en(digit_en)
    );

    mult_result_bcd #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .prod(prod), .prod_valid(prod_valid),
        .in_ready(nb_in_ready), .busy(nb_busy), .done(nb_done), .bcd_out(nb_bcd_out),
        .seg(nb_seg), .digit_en(nb_digit_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return tbl[d];
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int idx, input bit blank);
        int h = v / 100;
        int t = (v / 10) % 10;
        int o = v % 10;
        if (idx == 0) return seg_of(o);
        if (idx == 1) return (blank && h == 0 && t == 0) ? 7'h00 : seg_of(t);
        return (blank && h == 0) ? 7'h00 : seg_of(h);
    endfunction

    // Edges are counted since reset release. A product accepted at edge N is
    // shown from edge N+8; the converter accepts again from edge N+9.
    int m_edge      = 0;
    int m_free_at   = 0;
    int m_done_edge = -1;
    int m_pend      = 0;
    int m_val       = 0;
    bit m_done      = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int e;
        if (!rst_n) begin
            m_edge      <= 0;
            m_free_at   <= 0;
            m_done_edge <= -1;
            m_pend      <= 0;
            m_val       <= 0;
            m_done      <= 1'b0;
        end else begin
            e = m_edge + 1;
            m_edge <= e;
            m_done <= (e == m_done_edge);
            if (e == m_done_edge) m_val <= m_pend;
            if (e >= m_free_at && prod_valid) begin
                m_pend      <= int'(prod);
                m_done_edge <= e + 8;
                m_free_at   <= e + 9;
            end
        end
    end

    always @(negedge clk) begin : monitor
        bit exp_busy;
        int idx;
        exp_busy = (m_done_edge >= 0) && (m_edge < m_done_edge);
        idx      = (m_edge / SD) % 3;
        check("mon_busy",      busy,     exp_busy);
        check("mon_in_ready",  in_ready, !exp_busy);
        check("mon_done",      done,     m_done);
        check("mon_bcd",       bcd_out,  to_bcd(m_val));
        check("mon_digit_en",  digit_en, 3'b001 << idx);
        check("mon_seg",       seg,      exp_seg(m_val, idx, 1'b1));
        check("mon_nb_digit",  nb_digit_en, 3'b001 << idx);
        check("mon_nb_seg",    nb_seg,   exp_seg(m_val, idx, 1'b0));
        check("mon_nb_bcd",    nb_bcd_out, to_bcd(m_val));
    end

    // ---------------- helpers ----------------
    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        check("ready_timeout", in_ready, 1'b1);
    endtask

    // Accept v, then wait (bounded) for done; returns latency in edges.
    task automatic convert(input logic [7:0] v, output int lat);
        wait_ready();
        prod       = v;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
        check("accept_done_low", done, 1'b0);
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    typedef struct {
        logic [7:0]  prod;
        logic [11:0] exp_bcd;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int lat;
        int cnt1, cnt2, cnt4;

        vecs[0] = '{8'd0,   12'h000};
        vecs[1] = '{8'd9,   12'h009};
        vecs[2] = '{8'd99,  12'h099};
        vecs[3] = '{8'd100, 12'h100};
        vecs[4] = '{8'd255, 12'h255};
        vecs[5] = '{8'd1,   12'h001};
        vecs[6] = '{8'd10,  12'h010};
        vecs[7] = '{8'd128, 12'h128};
        vecs[8] = '{8'd199, 12'h199};
        vecs[9] = '{8'd200, 12'h200};

        rst_n      = 1'b1;
        prod_valid = 1'b0;
        prod       = 8'd0;
        #2 rst_n   = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy",     busy,     1'b0);
        check("rst_done",     done,     1'b0);
        check("rst_bcd",      bcd_out,  12'h000);
        check("rst_digit_en", digit_en, 3'b001);
        check("rst_seg",      seg,      7'h3F);
        rst_n = 1'b1;
        tick();

        // 225: busy exactly 8 cycles, done exactly after edge N+8
        prod       = 8'd225;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
        prod       = 8'd3;
        check("t1_busy_start", busy, 1'b1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("t1_busy", busy, 1'b1);
            check("t1_done_early", done, 1'b0);
        end
        tick();
        check("t1_done", done, 1'b1);
        check("t1_bcd", bcd_out, 12'h225);
        check("t1_busy_end", busy, 1'b0);
        tick();
        check("t1_done_width", done, 1'b0);
        check("t1_bcd_hold", bcd_out, 12'h225);

        // table-driven sweep, back-to-back at 9-cycle spacing
        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].prod, lat);
            check("vec_latency", lat, 8);
            check("vec_bcd", bcd_out, vecs[i].exp_bcd);
        end
        tick();
        check("vec_done_width", done, 1'b0);

        // 42 accepted, 7 held valid during conversion, accepted at N+9
        wait_ready();
        prod       = 8'd42;
        prod_valid = 1'b1;
        tick();
        prod = 8'd7;
        for (int i = 1; i < 8; i++) begin
            tick();
            check("t3_no_done", done, 1'b0);
        end
        tick();
        check("t3_done", done, 1'b1);
        check("t3_bcd", bcd_out, 12'h042);
        tick();
        check("t3_accept_n9", busy, 1'b1);
        check("t3_done_width", done, 1'b0);
        prod_valid = 1'b0;
        repeat (7) tick();
        check("t3_no_done2", done, 1'b0);
        tick();
        check("t3_done2", done, 1'b1);
        check("t3_bcd2", bcd_out, 12'h007);

        // reset in the middle of a conversion
        wait_ready();
        prod       = 8'd200;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("t4_in_ready", in_ready, 1'b1);
        check("t4_busy", busy, 1'b0);
        check("t4_bcd", bcd_out, 12'h000);
        check("t4_done", done, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (8) begin
            tick();
            check("t4_no_done", done, 1'b0);
        end
        convert(8'd5, lat);
        check("t4_latency", lat, 8);
        check("t4_bcd5", bcd_out, 12'h005);

        // display of 009: blanking vs. no blanking, 4 clocks per digit
        convert(8'd9, lat);
        check("t5_bcd", bcd_out, 12'h009);
        cnt1 = 0; cnt2 = 0; cnt4 = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            case (digit_en)
                3'b001: begin
                    cnt1++;
                    check("t5_seg_ones", seg, 7'h6F);
                    check("t5_nb_ones", nb_seg, 7'h6F);
                end
                3'b010: begin
                    cnt2++;
                    check("t5_seg_tens", seg, 7'h00);
                    check("t5_nb_tens", nb_seg, 7'h3F);
                end
                3'b100: begin
                    cnt4++;
                    check("t5_seg_hund", seg, 7'h00);
                    check("t5_nb_hund", nb_seg, 7'h3F);
                end
                default: check("t5_digit_onehot", digit_en, 3'b001);
            endcase
        end
        check("t5_ones_cycles", cnt1, 4);
        check("t5_tens_cycles", cnt2, 4);
        check("t5_hund_cycles", cnt4, 4);

        // exhaustive conversion
        for (int v = 0; v < 256; v++) begin
            convert(8'(v), lat);
            check("ex_latency", lat, 8);
            check("ex_bcd", bcd_out, to_bcd(v));
            check("ex_hund_le2", bcd_out[11:8] <= 4'd2, 1'b1);
            check("ex_tens_le9", bcd_out[7:4] <= 4'd9, 1'b1);
            check("ex_ones_le9", bcd_out[3:0] <= 4'd9, 1'b1);
        end

        // random traffic; the monitor checks every cycle
        for (int i = 0; i < 1500; i++) begin
            prod       = 8'($urandom);
            prod_valid = ($urandom_range(0, 2) != 0);
            tick();
        end
        prod_valid = 1'b0;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_result_bcd.md
Name: mult_result_bcd

Overview:
- Downstream consumer of the 4x4 shift-add multiplier's 8-bit product.
- Converts each accepted product to 3 BCD digits using a sequential double-dabble engine (one bit per clock), holds the result, and time-multiplexes the digits onto a 7-segment display.
- Sits between the multiplier datapath output and the user outputs of the top-level tile.

Parameters:
SCAN_DIV, 1024, clocks per displayed digit before advancing the scan (must be >=2)
BLANK_LZ, 1, 1 = blank leading-zero hundreds/tens digits; 0 = always show all three

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
prod  input  8  unsigned product from multiplier (0..255)
prod_valid  input  1  product valid; sampled only when in_ready=1
in_ready  output  1  high when converter is idle and accepts a product
busy  output  1  conversion in progress (= !in_ready)
done  output  1  one-cycle pulse: new bcd_out valid
bcd_out  output  12  {hundreds[3:0], tens[3:0], ones[3:0]}, held until next done
seg  output  7  {g,f,e,d,c,b,a}, active-high segments of current digit
digit_en  output  3  one-hot active-high digit select: [0]=ones, [1]=tens, [2]=hundreds

Behaviour:
- Reset (async assert, sync release effect): state=IDLE, bcd_out=12'h000, done=0, busy=0, in_ready=1, scan counter=0, digit_en=3'b001, seg=7'h3F.
- FSM states:
  - IDLE: in_ready=1. On an edge with prod_valid=1, load shift reg={12'h000, prod} and bit counter=0, then go to SHIFT.
  - SHIFT: each cycle, add 3 to any BCD nibble >=5, then shift left the whole 20-bit register by 1; counter++. On the 8th shift edge: register bcd_out with the final nibbles, set done=1, go to IDLE.
- Latency: prod_valid sampled at edge N -> bcd_out updated and done high for exactly the cycle following edge N+8. busy is high from edge N until edge N+8.
- prod_valid while busy: ignored, not queued. prod_valid at the same edge done rises is also ignored (FSM still in SHIFT at that edge); acceptance resumes from edge N+9.
- prod_valid held high continuously: a new conversion starts every 9 cycles, each capturing prod on its accept edge.
- The prod value is captured only at accept; later changes to prod do not affect the conversion in flight.
- Hundreds nibble is always 0..2; all nibbles are always 0..9.
- Reset mid-conversion: conversion aborted, outputs return to reset values, no done pulse.
- Display:
  - Free-running scan counter 0..SCAN_DIV-1. On wrap, digit_en rotates 001->010->100->001.
  - seg is a combinational decode of the bcd_out nibble selected by digit_en and is independent of conversion activity, so the display always shows the last completed result.
  - 7-segment codes 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - Blanking with BLANK_LZ=1: hundreds is blanked (seg=00) if it is 0; tens is blanked if both hundreds and tens are 0; ones is never blanked.
- The display scan runs during conversions and is reset only by rst_n.

Test Plan:
1. prod=8'd225 (15*15), prod_valid pulse at edge N -> done pulse after edge N+8 only; bcd_out=12'h225; busy high for exactly 8 cycles.
2. Sweep prod=0,9,99,100,255 back-to-back with 9-cycle spacing -> bcd_out=000,009,099,100,255; every done pulse is exactly 1 cycle wide.
3. prod=8'd42 accepted, then prod_valid=1 with prod=8'd7 at cycles N+1..N+8 -> single done, bcd_out=12'h042; prod=7 is accepted at N+9 -> bcd_out=12'h007 after edge N+17.
4. prod=200 accepted, rst_n low at N+4 for 2 cycles -> no done; bcd_out=000; in_ready=1 immediately; next prod=5 converts to 12'h005.
5. SCAN_DIV=4, BLANK_LZ=1, bcd_out=12'h009 -> digit_en cycles 001,010,100 every 4 clocks; seg=6F,00,00. Repeat with BLANK_LZ=0 -> seg=6F,3F,3F.
6. Exhaustive: every prod 0..255 -> bcd_out equals the decimal value; hundreds<=2; no nibble >9.
